// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-read-port register file with a reset-driven clear sweep
//
// Ports:
//   clk      single clock, all state changes on the rising edge
//   rst      synchronous active-low reset
//   we       write enable
//   waddr    write address
//   wdata    write data
//   raddr    packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata    packed read data, port k at [k*DATA_W +: DATA_W]
//   busy     high while reset is held or the clear sweep runs
//   wr_drop  one-cycle pulse after a write request that was discarded
//
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read bypass (write-first).
// Without it, reads are read-first with no combinational path from we/wdata.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                run;
    logic                wr_zero_tgt;
    logic                wr_ok;

    assign run         = (state == ST_RUN);
    assign wr_zero_tgt = (ZERO_REG != 0) && (waddr == '0);
    // A write is accepted only in RUN and never into the hardwired-zero entry.
    assign wr_ok       = run && we && !wr_zero_tgt;

    // Control FSM. busy is its own flop so it never depends on inputs combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_HOLD;
            sweep_cnt <= '0;
            busy      <= 1'b1;
            wr_drop   <= 1'b0;
        end else begin
            wr_drop <= we && (!run || wr_zero_tgt);
            case (state)
                ST_HOLD: begin
                    state     <= ST_CLEAR;
                    sweep_cnt <= '0;
                    busy      <= 1'b1;
                end
                ST_CLEAR: begin
                    // Leave on the edge that clears the last entry; the counter
                    // is left at DEPTH-1 rather than wrapping.
                    if (sweep_cnt == {ADDR_W{1'b1}}) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    busy <= 1'b0;
                end
                default: begin
                    state     <= ST_HOLD;
                    sweep_cnt <= '0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset so it can map onto a RAM; the sweep clears it instead.
    // The single write port is shared between the sweep and functional writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_CLEAR) begin
                mem[sweep_cnt] <= '0;
            end else if (wr_ok) begin
                mem[waddr] <= wdata;
            end
        end
    end

    // Read ports: lowest-priority source first, higher-priority overrides below.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (ra == waddr)) begin
                rd = wdata;
            end
`endif
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end
            if (busy) begin
                rd = '0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
    end

endmodule
